// File: rtl/posit_operand_sequencer.sv
// Posit operand sequencer: accepts A/B pairs, decodes them through Data_Extraction and
// presents a registered field bundle. Define POSIT_SEQ_DUAL_EN for two parallel extractors.

module Data_Extraction #(
    parameter int N  = 8,
    parameter int ES = 3,
    parameter int RS = $clog2(N)
) (
    input  logic [N-1:0]        In,
    output logic                Sign,
    output logic signed [RS+1:0] RegimeValue,
    output logic [ES-1:0]       Exponent,
    output logic [N-ES+2:0]     Mantissa
);
    logic [N-2:0] mag;
    logic [N-2:0] shifted;
    logic [RS:0]  run;
    logic [RS+1:0] run_x;
    logic         stop;

    always_comb begin
        // two's complement of the body for negative posits
        mag   = (In[N-2:0] ^ {(N-1){In[N-1]}}) + (N-1)'(In[N-1]);
        run   = '0;
        stop  = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!stop && (mag[i] == mag[N-2])) begin
                run = run + (RS+1)'(1);
            end else begin
                stop = 1'b1;
            end
        end
        run_x       = {1'b0, run};
        RegimeValue = mag[N-2] ? $signed(run_x - (RS+2)'(1)) : $signed(-run_x);
        // drop the regime run and its terminator, leaving exponent then fraction left-aligned
        shifted     = mag << (run_x + (RS+2)'(1));
        Sign        = In[N-1];
        Exponent    = shifted[N-2 -: ES];
        Mantissa    = {1'b1, shifted[N-ES-2:0], 3'b000};
    end
endmodule

// state | meaning
// IDLE  | waiting for an operand pair, InReady=1
// EXT_A | A operand decoded (both operands when POSIT_SEQ_DUAL_EN)
// EXT_B | B operand decoded through the shared extractor
// DONE  | bundle valid, held until OutReady
module posit_operand_sequencer #(
    parameter int N  = 8,
    parameter int ES = 3,
    parameter int RS = $clog2(N)
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [N-1:0]         InA,
    input  logic [N-1:0]         InB,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic                 SignA,
    output logic                 SignB,
    output logic signed [RS+1:0] RegimeA,
    output logic signed [RS+1:0] RegimeB,
    output logic [ES-1:0]        ExponentA,
    output logic [ES-1:0]        ExponentB,
    output logic [N-ES+2:0]      MantissaA,
    output logic [N-ES+2:0]      MantissaB,
    output logic                 ZeroA,
    output logic                 ZeroB,
    output logic                 NaRA,
    output logic                 NaRB,
    output logic                 Busy
);
`ifdef POSIT_SEQ_DUAL_EN
    typedef enum logic [1:0] {IDLE, EXT_A, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXT_A, EXT_B, DONE} state_t;
`endif

    localparam logic [N-1:0] NAR_PATTERN = {1'b1, {(N-1){1'b0}}};

    state_t state, next_state;
    logic   load, cap_a, cap_b;

    logic [N-1:0] op_a, op_b;

    logic                 ext_sign_a, ext_sign_b;
    logic signed [RS+1:0] ext_regime_a, ext_regime_b;
    logic [ES-1:0]        ext_exp_a, ext_exp_b;
    logic [N-ES+2:0]      ext_mant_a, ext_mant_b;

`ifdef POSIT_SEQ_DUAL_EN
    Data_Extraction #(.N(N), .ES(ES), .RS(RS)) u_ext_a (
        .In          (op_a),
        .Sign        (ext_sign_a),
        .RegimeValue (ext_regime_a),
        .Exponent    (ext_exp_a),
        .Mantissa    (ext_mant_a)
    );

    Data_Extraction #(.N(N), .ES(ES), .RS(RS)) u_ext_b (
        .In          (op_b),
        .Sign        (ext_sign_b),
        .RegimeValue (ext_regime_b),
        .Exponent    (ext_exp_b),
        .Mantissa    (ext_mant_b)
    );
`else
    logic [N-1:0]         ext_in;
    logic                 ext_sign;
    logic signed [RS+1:0] ext_regime;
    logic [ES-1:0]        ext_exp;
    logic [N-ES+2:0]      ext_mant;

    assign ext_in = (state == EXT_B) ? op_b : op_a;

    Data_Extraction #(.N(N), .ES(ES), .RS(RS)) u_ext (
        .In          (ext_in),
        .Sign        (ext_sign),
        .RegimeValue (ext_regime),
        .Exponent    (ext_exp),
        .Mantissa    (ext_mant)
    );

    assign ext_sign_a   = ext_sign;
    assign ext_sign_b   = ext_sign;
    assign ext_regime_a = ext_regime;
    assign ext_regime_b = ext_regime;
    assign ext_exp_a    = ext_exp;
    assign ext_exp_b    = ext_exp;
    assign ext_mant_a   = ext_mant;
    assign ext_mant_b   = ext_mant;
`endif

    logic zero_a, zero_b, nar_a, nar_b, special_a, special_b;

    assign zero_a    = (op_a == '0);
    assign zero_b    = (op_b == '0);
    assign nar_a     = (op_a == NAR_PATTERN);
    assign nar_b     = (op_b == NAR_PATTERN);
    assign special_a = zero_a | nar_a;
    assign special_b = zero_b | nar_b;

    assign InReady  = (state == IDLE) || ((state == DONE) && OutReady);
    assign OutValid = (state == DONE);
    assign Busy     = (state != IDLE);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        cap_a      = 1'b0;
        cap_b      = 1'b0;
        case (state)
            IDLE: begin
                if (InValid) begin
                    load       = 1'b1;
                    next_state = EXT_A;
                end
            end
`ifdef POSIT_SEQ_DUAL_EN
            EXT_A: begin
                cap_a      = 1'b1;
                cap_b      = 1'b1;
                next_state = DONE;
            end
`else
            EXT_A: begin
                cap_a      = 1'b1;
                next_state = EXT_B;
            end
            EXT_B: begin
                cap_b      = 1'b1;
                next_state = DONE;
            end
`endif
            DONE: begin
                if (OutReady) begin
                    if (InValid) begin
                        load       = 1'b1;
                        next_state = EXT_A;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            op_a      <= '0;
            op_b      <= '0;
            SignA     <= 1'b0;
            SignB     <= 1'b0;
            RegimeA   <= '0;
            RegimeB   <= '0;
            ExponentA <= '0;
            ExponentB <= '0;
            MantissaA <= '0;
            MantissaB <= '0;
            ZeroA     <= 1'b0;
            ZeroB     <= 1'b0;
            NaRA      <= 1'b0;
            NaRB      <= 1'b0;
        end else begin
            if (load) begin
                op_a <= InA;
                op_b <= InB;
            end
            // zero and NaR carry no meaningful fields, so they are cleared
            if (cap_a) begin
                ZeroA     <= zero_a;
                NaRA      <= nar_a;
                SignA     <= special_a ? 1'b0 : ext_sign_a;
                RegimeA   <= special_a ? '0 : ext_regime_a;
                ExponentA <= special_a ? '0 : ext_exp_a;
                MantissaA <= special_a ? '0 : ext_mant_a;
            end
            if (cap_b) begin
                ZeroB     <= zero_b;
                NaRB      <= nar_b;
                SignB     <= special_b ? 1'b0 : ext_sign_b;
                RegimeB   <= special_b ? '0 : ext_regime_b;
                ExponentB <= special_b ? '0 : ext_exp_b;
                MantissaB <= special_b ? '0 : ext_mant_b;
            end
        end
    end
endmodule

// File: tb/tb_posit_operand_sequencer.sv
// Self-checking bench for posit_operand_sequencer: directed cases plus randomized traffic
// compared against an arithmetic posit decoder and a transaction-level handshake model.
module tb_posit_operand_sequencer;
    localparam int N  = 8;
    localparam int ES = 3;
    localparam int RS = 3;
`ifdef POSIT_SEQ_DUAL_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic                 Clock = 1'b0;
    logic                 nReset;
    logic                 InValid;
    logic                 InReady;
    logic [N-1:0]         InA, InB;
    logic                 OutValid;
    logic                 OutReady;
    logic                 SignA, SignB;
    logic signed [RS+1:0] RegimeA, RegimeB;
    logic [ES-1:0]        ExponentA, ExponentB;
    logic [N-ES+2:0]      MantissaA, MantissaB;
    logic                 ZeroA, ZeroB, NaRA, NaRB;
    logic                 Busy;

    posit_operand_sequencer #(.N(N), .ES(ES), .RS(RS)) dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .InValid   (InValid),
        .InReady   (InReady),
        .InA       (InA),
        .InB       (InB),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .SignA     (SignA),
        .SignB     (SignB),
        .RegimeA   (RegimeA),
        .RegimeB   (RegimeB),
        .ExponentA (ExponentA),
        .ExponentB (ExponentB),
        .MantissaA (MantissaA),
        .MantissaB (MantissaB),
        .ZeroA     (ZeroA),
        .ZeroB     (ZeroB),
        .NaRA      (NaRA),
        .NaRB      (NaRB),
        .Busy      (Busy)
    );

    always #5 Clock = ~Clock;

    logic [18:0] dut_a, dut_b;
    logic [37:0] dut_bundle;
    assign dut_a      = {SignA, RegimeA, ExponentA, MantissaA, ZeroA, NaRA};
    assign dut_b      = {SignB, RegimeB, ExponentB, MantissaB, ZeroB, NaRB};
    assign dut_bundle = {dut_a, dut_b};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Posit decode from the number-format definition: sign, regime run, exponent, fraction.
    function automatic logic [18:0] ref_fields(input logic [7:0] x);
        int v, r0, run, k, rem, rv, e, fb, f, m;
        if (x == 8'h00) return {1'b0, 5'd0, 3'd0, 8'd0, 1'b1, 1'b0};
        if (x == 8'h80) return {1'b0, 5'd0, 3'd0, 8'd0, 1'b0, 1'b1};
        v   = x[7] ? (256 - int'(x)) : int'(x);
        r0  = (v >> 6) & 1;
        run = 0;
        for (int i = 6; i >= 0; i--) begin
            if (((v >> i) & 1) != r0) break;
            run++;
        end
        k   = (r0 == 1) ? run - 1 : -run;
        rem = (run >= 6) ? 0 : 6 - run;
        rv  = v & ((1 << rem) - 1);
        if (rem >= ES) begin
            e  = rv >> (rem - ES);
            fb = rem - ES;
            f  = rv & ((1 << fb) - 1);
        end else begin
            e  = rv << (ES - rem);
            fb = 0;
            f  = 0;
        end
        m = 128 | (f << (7 - fb));
        return {x[7], 5'(k), 3'(e), 8'(m), 1'b0, 1'b0};
    endfunction

    // transaction-level model: one pair in flight, LAT edges until the bundle is offered
    bit          m_inflight, m_valid;
    int          m_cnt;
    logic [37:0] m_next, m_bundle;
    int          n_consumed;

    task automatic model_reset();
        m_inflight = 0;
        m_valid    = 0;
        m_cnt      = 0;
        m_next     = '0;
        m_bundle   = '0;
    endtask

    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic ordy);
        bit exp_rdy, acc, cons;
        InValid  = v;
        InA      = a;
        InB      = b;
        OutReady = ordy;
        #1;
        exp_rdy = (!m_inflight && !m_valid) || (m_valid && ordy);
        chk("in_ready", InReady, exp_rdy);
        chk("out_valid", OutValid, m_valid);
        chk("busy", Busy, m_inflight || m_valid);
        if (m_valid) chk("bundle", dut_bundle, m_bundle);
        acc  = v && exp_rdy;
        cons = m_valid && ordy;
        @(posedge Clock);
        if (cons) begin
            m_valid = 0;
            n_consumed++;
        end
        if (m_inflight) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_inflight = 0;
                m_valid    = 1;
                m_bundle   = m_next;
            end
        end
        if (acc) begin
            m_inflight = 1;
            m_cnt      = LAT;
            m_next     = {ref_fields(a), ref_fields(b)};
        end
        #1;
    endtask

    function automatic logic [7:0] rand_operand();
        logic [7:0] specials [6];
        specials = '{8'h00, 8'h80, 8'h7F, 8'h81, 8'h01, 8'hFF};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        logic [7:0] sa [4];
        logic [7:0] sb [4];
        int idx;

        nReset   = 1'b0;
        InValid  = 1'b0;
        InA      = '0;
        InB      = '0;
        OutReady = 1'b0;
        model_reset();
        n_consumed = 0;

        repeat (2) @(posedge Clock);
        #1;
        chk("rst_out_valid", OutValid, 1'b0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_in_ready", InReady, 1'b1);
        chk("rst_fields", dut_bundle, 38'd0);
        @(negedge Clock);
        nReset = 1'b1;
        @(posedge Clock);
        #1;

        // 0x40 / 0xC0: +1 and -1
        step(1, 8'h40, 8'hC0, 1);
        repeat (LAT) step(0, 8'h00, 8'h00, 1);
        chk("dir_valid_lat", OutValid, 1'b1);
        chk("dir_sign_a", SignA, 1'b0);
        chk("dir_regime_a", RegimeA, 5'd0);
        chk("dir_exp_a", ExponentA, 3'd0);
        chk("dir_sign_b", SignB, 1'b1);
        chk("dir_regime_b", RegimeB, 5'd0);
        chk("dir_exp_b", ExponentB, 3'd0);
        chk("dir_flags", {ZeroA, NaRA, ZeroB, NaRB}, 4'b0000);
        step(0, 8'h00, 8'h00, 1);

        // zero / NaR
        step(1, 8'h00, 8'h80, 1);
        repeat (LAT) step(0, 8'h00, 8'h00, 0);
        chk("spc_zero_a", ZeroA, 1'b1);
        chk("spc_nar_b", NaRB, 1'b1);
        chk("spc_sign_b", SignB, 1'b0);
        chk("spc_fields", {dut_a[18:2], dut_b[18:2]}, 34'd0);

        // backpressure with a second pair waiting
        repeat (10) step(1, 8'h5B, 8'hA7, 0);
        step(1, 8'h5B, 8'hA7, 1);
        repeat (LAT) step(0, 8'h00, 8'h00, 0);
        chk("bp_second_valid", OutValid, 1'b1);
        step(0, 8'h00, 8'h00, 1);

        // stream four pairs with InValid and OutReady high
        for (int i = 0; i < 4; i++) begin
            sa[i] = rand_operand();
            sb[i] = rand_operand();
        end
        idx        = 0;
        n_consumed = 0;
        for (int c = 0; c < 4 * (LAT + 1) + 2; c++) begin
            if (idx < 4) begin
                step(1, sa[idx], sb[idx], 1);
                if (m_inflight && m_cnt == LAT) idx++;
            end else begin
                step(0, 8'h00, 8'h00, 1);
            end
        end
        chk("stream_count", n_consumed, 4);

        // asynchronous reset while the pair is mid-decode
        step(1, 8'h3C, 8'hC3, 0);
        step(0, 8'h00, 8'h00, 0);
        #3 nReset = 1'b0;
        #1;
        chk("arst_out_valid", OutValid, 1'b0);
        chk("arst_busy", Busy, 1'b0);
        chk("arst_in_ready", InReady, 1'b1);
        chk("arst_fields", dut_bundle, 38'd0);
        model_reset();
        #2 nReset = 1'b1;
        @(posedge Clock);
        #1;
        repeat (6) step(0, 8'h00, 8'h00, 1);

        // random traffic, operands changing every cycle
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, rand_operand(), rand_operand(),
                 ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
        end
        repeat (LAT + 2) step(0, 8'h00, 8'h00, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
